ifetch_basic: RTL and testbench



---
 rtl/ifetch_basic_pkg.sv | 39 +++
 rtl/ifetch_basic_psel.sv | 23 ++
 rtl/ifetch_basic.sv | 105 ++++++++++
 tb/tb_ifetch_basic.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_basic_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Packet layout and helpers used by the fetch FSM and its selector.
package ifetch_basic_pkg;

  localparam int XLEN = 32;

  // RISC-V canonical NOP: addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Request / grant bit positions, highest priority first.
  localparam int REQ_CERTAIN = 3;
  localparam int REQ_ROB     = 2;
  localparam int REQ_PRED    = 1;
  localparam int REQ_SEQ     = 0;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic            valid;
  } if_id_packet_t;

  localparam if_id_packet_t IDLE_PACKET = '{
    inst:  NOP,
    pc:    '0,
    npc:   '0,
    valid: 1'b0
  };

  function automatic logic [XLEN-1:0] block_addr(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:3], 3'b000};
  endfunction

  function automatic logic [31:0] select_inst(input logic [XLEN-1:0] pc,
                                              input logic [63:0]     blk);
    return pc[2] ? blk[63:32] : blk[31:0];
  endfunction

endpackage

// File: rtl/ifetch_basic_psel.sv
// Fixed-priority one-hot selector: grants the highest-index set request.
// The sequential request is always set, so the grant is never empty.
module psel_fixed
  import ifetch_basic_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt
);

  // Scanning upward lets the highest set bit overwrite any lower one.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ifetch_basic.sv
// Instruction-fetch stage: holds the fetch PC, addresses the icache and
// emits one registered IF/ID packet per completed fetch.
//
//   state  | meaning
//   FETCH  | waiting for if_valid and icache data at the current PC
//   ISSUED | packet valid this cycle; icache data ignored, back to FETCH
module ifetch_basic
  import ifetch_basic_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [XLEN-1:0] certain_branch_pc,
  input  logic            certain_branch_req,
  input  logic [XLEN-1:0] rob_target_pc,
  input  logic            rob_target_req,
  input  logic [XLEN-1:0] branch_pred_pc,
  input  logic            branch_pred_req,
  input  logic [63:0]     Icache2proc_data,
  input  logic            Icache2proc_data_valid,
  output if_id_packet_t   if_packet,
  output logic [XLEN-1:0] proc2Icache_addr,
  output logic [3:0]      req_debug,
  output logic [3:0]      gnt_debug,
  output logic [XLEN-1:0] PC_reg_debug
);

  localparam logic [0:0] FETCH  = 1'b0;
  localparam logic [0:0] ISSUED = 1'b1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [0:0]      state_q, state_d;
  if_id_packet_t   pkt_q, pkt_d;

  logic [3:0]      req;
  logic [3:0]      gnt;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;
  logic            redirect;
  logic            fetch_done;

  assign req[REQ_CERTAIN] = certain_branch_req;
  assign req[REQ_ROB]     = rob_target_req;
  assign req[REQ_PRED]    = branch_pred_req;
  assign req[REQ_SEQ]     = 1'b1;

  psel_fixed #(.WIDTH(4)) u_psel (
    .req (req),
    .gnt (gnt)
  );

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    case (gnt)
      4'b1000: next_pc = certain_branch_pc;
      4'b0100: next_pc = rob_target_pc;
      4'b0010: next_pc = branch_pred_pc;
      default: next_pc = pc_plus4;
    endcase
  end

  assign redirect   = gnt[REQ_CERTAIN] | gnt[REQ_ROB];
  assign fetch_done = (state_q == FETCH) && if_valid && Icache2proc_data_valid;

  // A redirect wins over everything, including a fetch completing this cycle.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    pkt_d   = IDLE_PACKET;
    if (redirect) begin
      pc_d    = next_pc;
      state_d = FETCH;
    end else if (state_q == ISSUED) begin
      state_d = FETCH;
    end else if (fetch_done) begin
      pkt_d.inst  = select_inst(pc_q, Icache2proc_data);
      pkt_d.pc    = pc_q;
      pkt_d.npc   = pc_plus4;
      pkt_d.valid = 1'b1;
      pc_d        = next_pc;
      state_d     = ISSUED;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= '0;
      state_q <= FETCH;
      pkt_q   <= IDLE_PACKET;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      pkt_q   <= pkt_d;
    end
  end

  assign if_packet        = pkt_q;
  assign proc2Icache_addr = block_addr(pc_q);
  assign req_debug        = req;
  assign gnt_debug        = gnt;
  assign PC_reg_debug     = pc_q;

endmodule

// File: tb/tb_ifetch_basic.sv
// Scoreboard bench for ifetch_basic: a transaction-level fetch model queues
// expected packets, a negedge monitor compares whatever the DUT presents.
module tb_ifetch_basic;
  import ifetch_basic_pkg::*;

  logic            clock = 1'b0;
  logic            reset;
  logic            if_valid;
  logic [31:0]     certain_branch_pc, rob_target_pc, branch_pred_pc;
  logic            certain_branch_req, rob_target_req, branch_pred_req;
  logic [63:0]     Icache2proc_data;
  logic            Icache2proc_data_valid;
  if_id_packet_t   if_packet;
  logic [31:0]     proc2Icache_addr;
  logic [3:0]      req_debug, gnt_debug;
  logic [31:0]     PC_reg_debug;

  always #5 clock = ~clock;

  ifetch_basic dut (
    .clock                  (clock),
    .reset                  (reset),
    .if_valid               (if_valid),
    .certain_branch_pc      (certain_branch_pc),
    .certain_branch_req     (certain_branch_req),
    .rob_target_pc          (rob_target_pc),
    .rob_target_req         (rob_target_req),
    .branch_pred_pc         (branch_pred_pc),
    .branch_pred_req        (branch_pred_req),
    .Icache2proc_data       (Icache2proc_data),
    .Icache2proc_data_valid (Icache2proc_data_valid),
    .if_packet              (if_packet),
    .proc2Icache_addr       (proc2Icache_addr),
    .req_debug              (req_debug),
    .gnt_debug              (gnt_debug),
    .PC_reg_debug           (PC_reg_debug)
  );

  // Backing memory: each 8-byte block holds two distinct address-derived words.
  function automatic logic [63:0] mem_block(input logic [31:0] a);
    logic [31:0] b;
    b = a & 32'hFFFF_FFF8;
    return {b ^ 32'hC0DE_0001, ~b + 32'h0000_1357};
  endfunction

  assign Icache2proc_data = mem_block(proc2Icache_addr);

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } exp_pkt_t;

  exp_pkt_t    exp_q[$];
  logic [31:0] pc_m = 32'd0;
  bit          busy_m = 1'b0;
  logic [3:0]  req_m = 4'd1;
  logic [3:0]  gnt_m = 4'd1;
  bit          mon_en = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the reference model advances at the same edge.
  task automatic step(input bit rst, input bit ifv, input bit icv,
                      input bit cert, input bit rob, input bit pred,
                      input logic [31:0] cpc, input logic [31:0] rpc,
                      input logic [31:0] ppc);
    logic [31:0] pc_next;
    bit          busy_next;
    logic [63:0] blk;
    reset                  = rst;
    if_valid               = ifv;
    Icache2proc_data_valid = icv;
    certain_branch_req     = cert;
    rob_target_req         = rob;
    branch_pred_req        = pred;
    certain_branch_pc      = cpc;
    rob_target_pc          = rpc;
    branch_pred_pc         = ppc;

    req_m = {cert, rob, pred, 1'b1};
    if (cert)      gnt_m = 4'b1000;
    else if (rob)  gnt_m = 4'b0100;
    else if (pred) gnt_m = 4'b0010;
    else           gnt_m = 4'b0001;

    pc_next   = pc_m;
    busy_next = 1'b0;
    if (rst) begin
      pc_next = 32'd0;
    end else if (cert) begin
      pc_next = cpc;
    end else if (rob) begin
      pc_next = rpc;
    end else if (!busy_m && ifv && icv) begin
      blk = mem_block(pc_m);
      exp_q.push_back('{inst: (pc_m[2] ? blk[63:32] : blk[31:0]),
                        pc: pc_m, npc: pc_m + 32'd4});
      pc_next   = pred ? ppc : pc_m + 32'd4;
      busy_next = 1'b1;
    end

    @(posedge clock);
    pc_m   = pc_next;
    busy_m = busy_next;
    if (rst) mon_en = 1'b1;
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 1, 1, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] v;
    v = 32'($urandom_range(0, 127)) << 2;
    if ($urandom_range(0, 7) == 0) v = v | 32'($urandom_range(1, 3));
    if ($urandom_range(0, 15) == 0) v = 32'hFFFF_FFF0 | (v & 32'hF);
    return v;
  endfunction

  always @(negedge clock) begin
    exp_pkt_t e;
    if (mon_en) begin
      chk("valid", 32'(if_packet.valid), 32'(busy_m));
      chk("pc_reg", PC_reg_debug, pc_m);
      chk("icache_addr", proc2Icache_addr, pc_m & 32'hFFFF_FFF8);
      chk("req", 32'(req_debug), 32'(req_m));
      chk("gnt", 32'(gnt_debug), 32'(gnt_m));
      if (if_packet.valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_packet: got pc %h expected no packet", if_packet.pc);
        end else begin
          e = exp_q.pop_front();
          chk("pkt_inst", if_packet.inst, e.inst);
          chk("pkt_pc", if_packet.pc, e.pc);
          chk("pkt_npc", if_packet.npc, e.npc);
        end
      end else begin
        chk("idle_inst", if_packet.inst, NOP);
      end
    end
  end

  initial begin
    reset = 1'b1;
    if_valid = 1'b0;
    Icache2proc_data_valid = 1'b0;
    certain_branch_req = 1'b0;
    rob_target_req = 1'b0;
    branch_pred_req = 1'b0;
    certain_branch_pc = '0;
    rob_target_pc = '0;
    branch_pred_pc = '0;
    @(negedge clock);

    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Sequential fetch from 0: packets 0x0, 0x4, 0x8 with gaps between them.
    idle(6);
    // All three redirects at once: certain branch wins.
    step(0, 1, 1, 1, 1, 1, 32'h100, 32'h200, 32'h300);
    idle(3);
    // Prediction taken on the completion of fetch 0x0.
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1, 0, 0, 32'h40);
    idle(3);
    // Stall with icache valid: PC held, nothing issued; a redirect still lands.
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0, 0, 32'h80, 0);
    idle(3);
    // Wrap of PC+4 and a misaligned redirect target.
    step(0, 1, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, 0);
    idle(4);
    step(0, 1, 0, 1, 0, 0, 32'h0000_0102, 0, 0);
    idle(4);
    // Reset while a packet is being presented.
    step(0, 1, 0, 0, 1, 0, 0, 32'h20, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(2);

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 11) == 0,
           $urandom_range(0, 11) == 0,
           $urandom_range(0, 3) == 0,
           rnd_pc(), rnd_pc(), rnd_pc());
    end

    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
